regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port of the rv32i core between two writeback sources: the ALU result path (port A) and the load-return path (port M). Each source presents a valid/ready request carrying a destination register and 32-bit data. The block grants one request per cycle with round-robin priority and registers the winning write. It drives the write port's address, data, enable and the one-hot per-register write-select vector, produced by an internal `decoder_5_to_32`. It also keeps a saturating count of contention cycles for performance monitoring.

## Interface
Parameters:
- `CNT_W`, default 16: width of the contention counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  ALU writeback request.
- `a_rd`  in  5  ALU destination register.
- `a_data`  in  32  ALU write data.
- `a_ready`  out  1  ALU request granted this cycle (combinational).
- `m_valid`  in  1  load writeback request.
- `m_rd`  in  5  load destination register.
- `m_data`  in  32  load write data.
- `m_ready`  out  1  load request granted this cycle (combinational).
- `wr_ena`  out  1  registered write enable to the register file.
- `wr_addr`  out  5  registered write address.
- `wr_data`  out  32  registered write data.
- `wr_sel`  out  32  one-hot write select, `decoder_5_to_32(ena = wr_ena, in = wr_addr)`; bit 0 forced to 0.
- `conflict_cnt`  out  `CNT_W`  saturating count of cycles where both requests were valid.

## Operation
- State:
  - `prio` is 1 bit: 0 means A wins a tie, 1 means M wins a tie.
  - Output registers hold `wr_ena`, `wr_addr` and `wr_data`.
  - `conflict_cnt` is a counter.
- Grant logic (combinational, same cycle):
  - Only `a_valid` is high: `a_ready = 1`.
  - Only `m_valid` is high: `m_ready = 1`.
  - Both are high: the `prio` side gets ready; the other side gets 0.
  - Neither is high: both readies are 0.
  - At most one ready is ever high.
  - Ready never asserts without its own valid.
- Requester rule: valid, rd and data are held stable until the matching ready is sampled high. Dropping valid before the grant is allowed and is simply not serviced.
- Priority update:
  - On any grant under contention (both valid), `prio` points to the loser.
  - On an uncontended grant, `prio` points to the side that was not granted.
  - With no grant, `prio` holds.
- Accept (edge with a grant): `wr_addr` and `wr_data` load from the granted port. `wr_ena` is set to 1 if the granted rd is not 0, else 0 (an x0 write is consumed but suppressed).
- No grant at the edge: `wr_ena` is set to 0. `wr_addr` and `wr_data` hold their previous values.
- `wr_sel` is combinational from the output registers through `decoder_5_to_32`, then masked with `~32'h1`. It is all-zero whenever `wr_ena = 0`.
- `conflict_cnt` increments on every edge where `a_valid & m_valid`, and saturates at all-ones.

## Timing
- Latency: a request granted at edge T appears on `wr_*` during cycle T+1. The register file commits it at edge T+1.
- Throughput: one write per cycle. Back-to-back grants to the same or alternating ports are allowed.
- Sustained contention: grants alternate A, M, A, M…; neither port waits more than 1 cycle.
- Same rd on both ports in one contended cycle: both writes reach the register file in grant order, so the later-granted data is final.
- Reset (synchronous, takes priority over all activity, including a grant in the same cycle):
  - `wr_ena = 0`, `wr_addr = 0`, `wr_data = 0`, `wr_sel = 0`, `conflict_cnt = 0`, `prio = 0`.
  - `a_ready` and `m_ready` follow their combinational rule; a grant coincident with reset is discarded.

## Test plan
- Single ALU request `a_rd = 5`, `a_data = 0xDEADBEEF`: `a_ready = 1` that cycle. Next cycle `wr_ena = 1`, `wr_addr = 5`, `wr_sel = 0x00000020`, `wr_data = 0xDEADBEEF`.
- Both valid for 4 cycles from reset (A: rd 1, M: rd 2):
  - Grants are A, M, A, M.
  - `wr_addr` sequence is 1, 2, 1, 2.
  - `conflict_cnt = 4`.
- Write to x0 (`m_rd = 0`, data `0x1234`): `m_ready = 1`, next cycle `wr_ena = 0` and `wr_sel = 0`, `prio` flips to 0.
- Same rd collision (A and M both rd 7, A data `0x11`, M data `0x22`, `prio = 0`): writes appear as `0x11` then `0x22`; a bench register-file model holds `0x22` for x7.
- Assert `rst` in the same cycle as a grant with `wr_ena` previously 1:
  - Next cycle, all outputs are 0 and `conflict_cnt = 0`.
  - The discarded request, still held valid, is granted on the following cycle.
- Saturation with `CNT_W = 3`: hold both valid for 10 cycles; `conflict_cnt` stops at 7.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_5_to_32 / regfile_write_arbiter
//
// decoder_5_to_32: one-hot decode of a 5-bit register index, gated by an enable.
//   ena  in  1   decode enable; output is all-zero when low
//   in   in  5   register index
//   out  out 32  one-hot select
//
// regfile_write_arbiter: shares the single register-file write port of the
// rv32i core between the ALU writeback path (port A) and the load-return path
// (port M). One request is granted per cycle with round-robin tie-breaking.
// The winning write is registered onto the wr_* outputs.
//   clk, rst               clock, synchronous active-high reset
//   a_valid/a_rd/a_data    ALU writeback request
//   a_ready                ALU request granted this cycle (combinational)
//   m_valid/m_rd/m_data    load writeback request
//   m_ready                load request granted this cycle (combinational)
//   wr_ena/wr_addr/wr_data registered write to the register file
//   wr_sel                 one-hot write select from wr_ena/wr_addr, x0 never set
//   conflict_cnt           saturating count of cycles with both requests valid
// -----------------------------------------------------------------------------

module decoder_5_to_32 (
  input  logic        ena,
  input  logic [4:0]  in,
  output logic [31:0] out
);

  always_comb begin
    // NOTE: default first, so no path through this block leaves out unassigned
    // (that would infer a latch).
    out = '0;
    if (ena) begin
      out[in] = 1'b1;
    end
  end

endmodule

module regfile_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [4:0]       a_rd,
  input  logic [31:0]      a_data,
  output logic             a_ready,
  input  logic             m_valid,
  input  logic [4:0]       m_rd,
  input  logic [31:0]      m_data,
  output logic             m_ready,
  output logic             wr_ena,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [31:0]      wr_sel,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Tie-break owner: 0 -> A wins a tie, 1 -> M wins a tie.
  logic        prio;
  logic [31:0] dec_sel;

  // Each side is granted when it is valid and either uncontested or owns the
  // tie; the two terms are mutually exclusive for any value of prio.
  assign a_ready = a_valid & (~m_valid | ~prio);
  assign m_ready = m_valid & (~a_valid |  prio);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      wr_ena       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_ready) begin
        wr_ena  <= (a_rd != 5'd0);   // x0 writes are consumed but suppressed
        wr_addr <= a_rd;
        wr_data <= a_data;
        prio    <= 1'b1;             // next tie goes to the side not served
      end else if (m_ready) begin
        wr_ena  <= (m_rd != 5'd0);
        wr_addr <= m_rd;
        wr_data <= m_data;
        prio    <= 1'b0;
      end else begin
        wr_ena  <= 1'b0;             // address/data hold their last values
      end

      if (a_valid && m_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  decoder_5_to_32 u_dec (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (dec_sel)
  );

  // x0 is hard-wired zero in the register file, so its select is never driven.
  assign wr_sel = dec_sel & ~32'h1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  typedef enum logic [1:0] {S_NONE, S_A, S_M} side_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, m_valid;
  logic [4:0]  a_rd, m_rd;
  logic [31:0] a_data, m_data;

  logic        a_ready, m_ready, wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, wr_sel;
  logic [15:0] conflict_cnt;

  logic        a_ready3, m_ready3, wr_ena3;
  logic [4:0]  wr_addr3;
  logic [31:0] wr_data3, wr_sel3;
  logic [2:0]  conflict_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file as seen by the core, filled from the DUT's write port.
  logic [31:0] rf [32];

  // Behavioural model state.
  bit          live = 1'b0;
  side_t       tie;
  logic        me_ena;
  logic [4:0]  me_addr;
  logic [31:0] me_data;
  int          cnt_big, cnt_small;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel),
    .conflict_cnt(conflict_cnt)
  );

  regfile_write_arbiter #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready3),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready3),
    .wr_ena(wr_ena3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_sel(wr_sel3),
    .conflict_cnt(conflict_cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic side_t winner(input logic av, input logic mv, input side_t t);
    if (av && mv) return t;
    if (av)       return S_A;
    if (mv)       return S_M;
    return S_NONE;
  endfunction

  // Model: who wins, what lands on the write port, how many contended cycles.
  always @(posedge clk) begin : model_p
    side_t w;
    w = winner(a_valid, m_valid, tie);
    if (rst) begin
      live = 1'b1; tie = S_A; me_ena = 1'b0; me_addr = '0; me_data = '0;
      cnt_big = 0; cnt_small = 0;
    end else begin
      if (a_valid && m_valid) begin
        cnt_big   = (cnt_big   < 65535) ? cnt_big + 1   : cnt_big;
        cnt_small = (cnt_small < 7)     ? cnt_small + 1 : cnt_small;
      end
      case (w)
        S_A: begin me_addr = a_rd; me_data = a_data; me_ena = (a_rd != 0); tie = S_M; end
        S_M: begin me_addr = m_rd; me_data = m_data; me_ena = (m_rd != 0); tie = S_A; end
        default: me_ena = 1'b0;
      endcase
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : compare_p
    side_t       w;
    logic [31:0] exp_sel;
    if (live) begin
      w       = winner(a_valid, m_valid, tie);
      exp_sel = me_ena ? (32'h1 << me_addr) : 32'h0;
      check("a_ready",       {31'b0, a_ready},  {31'b0, w == S_A});
      check("m_ready",       {31'b0, m_ready},  {31'b0, w == S_M});
      check("wr_ena",        {31'b0, wr_ena},   {31'b0, me_ena});
      check("wr_addr",       {27'b0, wr_addr},  {27'b0, me_addr});
      check("wr_data",       wr_data,           me_data);
      check("wr_sel",        wr_sel,            exp_sel);
      check("conflict_cnt",  {16'b0, conflict_cnt}, 32'(cnt_big));
      check("a_ready3",      {31'b0, a_ready3}, {31'b0, w == S_A});
      check("m_ready3",      {31'b0, m_ready3}, {31'b0, w == S_M});
      check("wr_ena3",       {31'b0, wr_ena3},  {31'b0, me_ena});
      check("wr_addr3",      {27'b0, wr_addr3}, {27'b0, me_addr});
      check("wr_data3",      wr_data3,          me_data);
      check("wr_sel3",       wr_sel3,           exp_sel);
      check("conflict_cnt3", {29'b0, conflict_cnt3}, 32'(cnt_small));
      if (wr_ena) rf[wr_addr] = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; m_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seq [4];
    seq = '{1, 2, 1, 2};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    a_rd = '0; m_rd = '0; a_data = '0; m_data = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_wr_ena",  {31'b0, wr_ena}, 32'h0);
    check("rst_wr_addr", {27'b0, wr_addr}, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_wr_sel",  wr_sel, 32'h0);
    check("rst_cnt",     {16'b0, conflict_cnt}, 32'h0);

    // Single ALU request.
    step();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_a_ready", {31'b0, a_ready}, 32'h1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("t1_wr_ena",  {31'b0, wr_ena}, 32'h1);
    check("t1_wr_addr", {27'b0, wr_addr}, 32'd5);
    check("t1_wr_sel",  wr_sel, 32'h00000020);
    check("t1_wr_data", wr_data, 32'hDEADBEEF);

    // Sustained contention from reset: A, M, A, M.
    do_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
    m_valid = 1'b1; m_rd = 5'd2; m_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) check("t2_wr_addr", {27'b0, wr_addr}, 32'(seq[i-1]));
      check("t2_a_ready", {31'b0, a_ready}, {31'b0, (i % 2) == 0});
      check("t2_m_ready", {31'b0, m_ready}, {31'b0, (i % 2) == 1});
      step();
    end
    a_valid = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("t2_wr_addr", {27'b0, wr_addr}, 32'(seq[3]));
    check("t2_cnt",     {16'b0, conflict_cnt}, 32'd4);

    // Write to x0 from M: consumed, suppressed.
    step();
    m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h1234;
    @(negedge clk);
    check("t3_m_ready", {31'b0, m_ready}, 32'h1);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    check("t3_wr_ena",  {31'b0, wr_ena}, 32'h0);
    check("t3_wr_sel",  wr_sel, 32'h0);
    check("t3_wr_data", wr_data, 32'h1234);

    // Same-rd collision with A owning the tie.
    step();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h11;
    m_valid = 1'b1; m_rd = 5'd7; m_data = 32'h22;
    @(negedge clk);
    check("t4_a_ready", {31'b0, a_ready}, 32'h1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("t4_wr_data1", wr_data, 32'h11);
    check("t4_m_ready",  {31'b0, m_ready}, 32'h1);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    check("t4_wr_data2", wr_data, 32'h22);
    step();
    check("t4_rf_x7", rf[7], 32'h22);

    // Reset coincident with a grant while wr_ena is high.
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    step();
    a_rd = 5'd10; a_data = 32'hAA; rst = 1'b1;
    @(negedge clk);
    check("t5_pre_wr_ena", {31'b0, wr_ena}, 32'h1);
    check("t5_pre_ready",  {31'b0, a_ready}, 32'h1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_wr_ena",  {31'b0, wr_ena}, 32'h0);
    check("t5_wr_addr", {27'b0, wr_addr}, 32'h0);
    check("t5_wr_data", wr_data, 32'h0);
    check("t5_wr_sel",  wr_sel, 32'h0);
    check("t5_cnt",     {16'b0, conflict_cnt}, 32'h0);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("t5_regrant_ena",  {31'b0, wr_ena}, 32'h1);
    check("t5_regrant_addr", {27'b0, wr_addr}, 32'd10);
    check("t5_regrant_data", wr_data, 32'hAA);

    // Counter saturation on the 3-bit instance.
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3;
    m_valid = 1'b1; m_rd = 5'd4; m_data = 32'h4;
    repeat (10) step();
    a_valid = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("t6_cnt3_sat", {29'b0, conflict_cnt3}, 32'd7);
    check("t6_cnt16",    {16'b0, conflict_cnt}, 32'd10);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
